// File: rtl/cacc_dlv_pkg.sv
// Shared constants and parameter derivations for the CACC delivery buffer.
package cacc_dlv_pkg;

  // Flag offsets above the data field: pd = {layer_end, batch_end, data}
  localparam int unsigned LAYER_END_BIT = 1;
  localparam int unsigned BATCH_END_BIT = 0;
  localparam int unsigned CREDIT_W      = 3;

  function automatic int unsigned calc_ratio(int unsigned dbuf_width, int unsigned sdp_dwidth);
    return (sdp_dwidth == 0) ? 0 : dbuf_width / sdp_dwidth;
  endfunction

  function automatic int unsigned calc_bwidth(int unsigned ratio);
    return (ratio < 1) ? 1 : $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/cacc_dlv_ram.sv
// Delivery entry RAM: sync read, 1-cycle latency, old data returned on same-address collision.
module cacc_dlv_ram #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned WIDTH  = 512,
  parameter int unsigned AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [AWIDTH-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              rd_en_i,
  input  logic [AWIDTH-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Output register only updates on a read, so it holds the entry for the whole burst.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/cacc_delivery_buffer_gen2.sv
// CACC->SDP delivery buffer: serialises RAM entries into SDP beats, raises done, coalesces credits.
// Define CACC_DLV_OUT_REG_EN to add a 2-entry skid register on the SDP output.
module cacc_delivery_buffer_gen2
  import cacc_dlv_pkg::*;
#(
  parameter int unsigned DBUF_DEPTH   = 32,
  parameter int unsigned DBUF_WIDTH   = 512,
  parameter int unsigned SDP_DWIDTH   = 128,
  parameter int unsigned CREDIT_BATCH = 1,
  parameter int unsigned AWIDTH       = $clog2(DBUF_DEPTH),
  parameter int unsigned BWIDTH       = calc_bwidth(calc_ratio(DBUF_WIDTH, SDP_DWIDTH))
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rst,
  input  logic                  dbuf_wr_en,
  input  logic [AWIDTH-1:0]     dbuf_wr_addr,
  input  logic [DBUF_WIDTH-1:0] dbuf_wr_data,
  input  logic                  dbuf_rd_en,
  input  logic [AWIDTH-1:0]     dbuf_rd_addr,
  input  logic [BWIDTH-1:0]     dbuf_rd_beats,
  input  logic                  dbuf_rd_layer_end,
  output logic                  dbuf_rd_ready,
  output logic                  cacc2sdp_valid,
  input  logic                  cacc2sdp_ready,
  output logic [SDP_DWIDTH+1:0] cacc2sdp_pd,
  output logic [1:0]            cacc2glb_done_intr_pd,
  output logic                  accu2sc_credit_vld,
  output logic [CREDIT_W-1:0]   accu2sc_credit_size
);

  localparam int unsigned RATIO = calc_ratio(DBUF_WIDTH, SDP_DWIDTH);
  localparam int unsigned PDW   = SDP_DWIDTH + 2;

  if (RATIO < 1 || RATIO * SDP_DWIDTH != DBUF_WIDTH) begin : g_bad_ratio
    $error("DBUF_WIDTH must be a non-zero integer multiple of SDP_DWIDTH");
  end
  if (CREDIT_BATCH < 1 || CREDIT_BATCH > 7) begin : g_bad_batch
    $error("CREDIT_BATCH must be in 1..7");
  end

  logic                  rd_acc;
  logic [BWIDTH-1:0]     eff_beats;
  logic [BWIDTH-1:0]     beats_left_q, beats_left_d;
  logic [BWIDTH-1:0]     beat_idx_q, beat_idx_d;
  logic                  layer_end_q, layer_end_d;
  logic [DBUF_WIDTH-1:0] ram_rd_data;
  logic [SDP_DWIDTH-1:0] beat_data;
  logic                  core_valid, core_ready, core_last, core_hs;
  logic [PDW-1:0]        core_pd;
  logic                  fin, fin_layer;
  logic                  intr_sel_q, intr_sel_d;
  logic [1:0]            intr_q, intr_d;
  logic [CREDIT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [CREDIT_W-1:0]   credit_size_q, credit_size_d;
  logic                  credit_vld_q, credit_vld_d;

  assign core_valid    = (beats_left_q != '0);
  assign core_last     = (beats_left_q == BWIDTH'(1));
  assign core_hs       = core_valid & core_ready;
  assign dbuf_rd_ready = ~core_valid;
  assign rd_acc        = dbuf_rd_en & dbuf_rd_ready;
  assign eff_beats     = (dbuf_rd_beats == '0 || dbuf_rd_beats > BWIDTH'(RATIO)) ?
                         BWIDTH'(RATIO) : dbuf_rd_beats;

  cacc_dlv_ram #(
    .DEPTH (DBUF_DEPTH),
    .WIDTH (DBUF_WIDTH),
    .AWIDTH(AWIDTH)
  ) u_ram (
    .clk_i    (nvdla_core_clk),
    .wr_en_i  (dbuf_wr_en),
    .wr_addr_i(dbuf_wr_addr),
    .wr_data_i(dbuf_wr_data),
    .rd_en_i  (rd_acc),
    .rd_addr_i(dbuf_rd_addr),
    .rd_data_o(ram_rd_data)
  );

  always_comb begin
    beat_data = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (beat_idx_q == BWIDTH'(i)) beat_data = ram_rd_data[i*SDP_DWIDTH +: SDP_DWIDTH];
    end
  end

  // Outputs are zeroed while idle so nothing stale leaks out of the RAM register.
  always_comb begin
    core_pd = '0;
    if (core_valid) begin
      core_pd[SDP_DWIDTH-1:0]             = beat_data;
      core_pd[SDP_DWIDTH + LAYER_END_BIT] = layer_end_q & core_last;
      core_pd[SDP_DWIDTH + BATCH_END_BIT] = 1'b0;
    end
  end

  always_comb begin
    beats_left_d = beats_left_q;
    beat_idx_d   = beat_idx_q;
    layer_end_d  = layer_end_q;
    if (rd_acc) begin
      beats_left_d = eff_beats;
      beat_idx_d   = '0;
      layer_end_d  = dbuf_rd_layer_end;
    end else if (core_hs) begin
      beats_left_d = beats_left_q - BWIDTH'(1);
      beat_idx_d   = beat_idx_q + BWIDTH'(1);
      if (core_last) layer_end_d = 1'b0;
    end
  end

`ifdef CACC_DLV_OUT_REG_EN
  logic [PDW:0]   skid_mem_q [2];
  logic [1:0]     skid_cnt_q;
  logic           skid_wr_q, skid_rd_q, skid_push, skid_pop, skid_last;
  logic [PDW-1:0] skid_pd;

  // Ready depends only on skid occupancy, so SDP ready never reaches an output combinationally.
  assign core_ready     = (skid_cnt_q != 2'd2);
  assign skid_push      = core_valid & core_ready;
  assign cacc2sdp_valid = (skid_cnt_q != 2'd0);
  assign skid_pop       = cacc2sdp_valid & cacc2sdp_ready;
  assign {skid_last, skid_pd} = skid_mem_q[skid_rd_q];
  assign cacc2sdp_pd    = cacc2sdp_valid ? skid_pd : '0;
  assign fin            = skid_pop & skid_last;
  assign fin_layer      = skid_pd[SDP_DWIDTH + LAYER_END_BIT];

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      skid_cnt_q <= 2'd0;
      skid_wr_q  <= 1'b0;
      skid_rd_q  <= 1'b0;
    end else begin
      if (skid_push) begin
        skid_mem_q[skid_wr_q] <= {core_last, core_pd};
        skid_wr_q             <= ~skid_wr_q;
      end
      if (skid_pop) skid_rd_q <= ~skid_rd_q;
      skid_cnt_q <= skid_cnt_q + {1'b0, skid_push} - {1'b0, skid_pop};
    end
  end
`else
  assign core_ready     = cacc2sdp_ready;
  assign cacc2sdp_valid = core_valid;
  assign cacc2sdp_pd    = core_pd;
  assign fin            = core_hs & core_last;
  assign fin_layer      = layer_end_q;
`endif

  assign cnt_inc = cnt_q + CREDIT_W'(1);

  always_comb begin
    intr_d        = 2'b00;
    intr_sel_d    = intr_sel_q;
    cnt_d         = cnt_q;
    credit_vld_d  = 1'b0;
    credit_size_d = '0;
    if (fin) begin
      if (fin_layer) begin
        intr_d     = intr_sel_q ? 2'b10 : 2'b01;
        intr_sel_d = ~intr_sel_q;
      end
      // A layer end flushes a partial batch so CSC is never left owed credits.
      if (cnt_inc == CREDIT_W'(CREDIT_BATCH) || fin_layer) begin
        credit_vld_d  = 1'b1;
        credit_size_d = cnt_inc;
        cnt_d         = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      beats_left_q  <= '0;
      beat_idx_q    <= '0;
      layer_end_q   <= 1'b0;
      intr_sel_q    <= 1'b0;
      intr_q        <= 2'b00;
      cnt_q         <= '0;
      credit_vld_q  <= 1'b0;
      credit_size_q <= '0;
    end else begin
      beats_left_q  <= beats_left_d;
      beat_idx_q    <= beat_idx_d;
      layer_end_q   <= layer_end_d;
      intr_sel_q    <= intr_sel_d;
      intr_q        <= intr_d;
      cnt_q         <= cnt_d;
      credit_vld_q  <= credit_vld_d;
      credit_size_q <= credit_size_d;
    end
  end

  assign cacc2glb_done_intr_pd = intr_q;
  assign accu2sc_credit_vld    = credit_vld_q;
  assign accu2sc_credit_size   = credit_size_q;

endmodule

// File: tb/tb_cacc_delivery_buffer_gen2.sv
// Scoreboard bench for cacc_delivery_buffer_gen2 (RATIO=4, CREDIT_BATCH=3).
module tb_cacc_delivery_buffer_gen2;

  localparam int DW    = 512;
  localparam int SW    = 128;
  localparam int PW    = SW + 2;
  localparam int AW    = 5;
  localparam int BW    = 3;
  localparam int RATIO = 4;
  localparam int CB    = 3;
`ifdef CACC_DLV_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic          last;
    logic [PW-1:0] pd;
  } exp_beat_t;

  logic          clk, rst;
  logic          dbuf_wr_en, dbuf_rd_en, dbuf_rd_layer_end, dbuf_rd_ready;
  logic [AW-1:0] dbuf_wr_addr, dbuf_rd_addr;
  logic [DW-1:0] dbuf_wr_data;
  logic [BW-1:0] dbuf_rd_beats;
  logic          cacc2sdp_valid, cacc2sdp_ready, credit_vld;
  logic [PW-1:0] cacc2sdp_pd;
  logic [1:0]    intr;
  logic [2:0]    credit_size;

  exp_beat_t     beat_q[$];
  int            credit_q[$];
  logic [1:0]    intr_q[$];
  logic [DW-1:0] mem_m [32];
  int            cnt_m;
  bit            sel_m;
  int            checks, errors;

  cacc_delivery_buffer_gen2 #(.CREDIT_BATCH(CB)) dut (
    .nvdla_core_clk       (clk),
    .nvdla_core_rst       (rst),
    .dbuf_wr_en           (dbuf_wr_en),
    .dbuf_wr_addr         (dbuf_wr_addr),
    .dbuf_wr_data         (dbuf_wr_data),
    .dbuf_rd_en           (dbuf_rd_en),
    .dbuf_rd_addr         (dbuf_rd_addr),
    .dbuf_rd_beats        (dbuf_rd_beats),
    .dbuf_rd_layer_end    (dbuf_rd_layer_end),
    .dbuf_rd_ready        (dbuf_rd_ready),
    .cacc2sdp_valid       (cacc2sdp_valid),
    .cacc2sdp_ready       (cacc2sdp_ready),
    .cacc2sdp_pd          (cacc2sdp_pd),
    .cacc2glb_done_intr_pd(intr),
    .accu2sc_credit_vld   (credit_vld),
    .accu2sc_credit_size  (credit_size)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pattern(input int addr, input int salt);
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = 32'hD000_0000 + 32'(salt << 16) + 32'(addr << 8) + 32'(i);
    return d;
  endfunction

  task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic write_entry(input int addr, input logic [DW-1:0] d);
    dbuf_wr_en = 1'b1; dbuf_wr_addr = AW'(addr); dbuf_wr_data = d;
    @(posedge clk); #1;
    dbuf_wr_en = 1'b0;
    mem_m[addr] = d;
  endtask

  // Issues one read; track=0 means the entry is expected to be killed by reset.
  task automatic issue(input int addr, input int beats, input bit le, input bit track,
                       input bit coll, input logic [DW-1:0] wdata);
    int eff, guard;
    eff = (beats == 0) ? RATIO : beats;
    guard = 0;
    while (!dbuf_rd_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("rd_ready_wait", PW'(dbuf_rd_ready), PW'(1));
    dbuf_rd_en = 1'b1; dbuf_rd_addr = AW'(addr); dbuf_rd_beats = BW'(beats);
    dbuf_rd_layer_end = le;
    if (coll) begin
      dbuf_wr_en = 1'b1; dbuf_wr_addr = AW'(addr); dbuf_wr_data = wdata;
    end
    for (int i = 0; i < eff; i++) begin
      exp_beat_t e;
      e.last = (i == eff - 1);
      e.pd = {le & e.last, 1'b0, mem_m[addr][i*SW +: SW]};
      beat_q.push_back(e);
    end
    if (track) begin
      if (le) begin
        intr_q.push_back(sel_m ? 2'b10 : 2'b01);
        sel_m = ~sel_m;
      end
      if (le || cnt_m + 1 == CB) begin
        credit_q.push_back(cnt_m + 1);
        cnt_m = 0;
      end else begin
        cnt_m++;
      end
    end
    @(posedge clk); #1;
    dbuf_rd_en = 1'b0; dbuf_wr_en = 1'b0; dbuf_rd_layer_end = 1'b0;
    if (coll) mem_m[addr] = wdata;
  endtask

  // Monitor: pops expectations on every DUT beat/credit/interrupt, checks timing and stall hold.
  initial begin
    exp_beat_t     e;
    logic          lp, sp, nlp;
    logic [PW-1:0] ppd;
    int            c;
    logic [1:0]    ei;
    lp = 1'b0; sp = 1'b0; ppd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        lp = 1'b0; sp = 1'b0;
      end else begin
        if (credit_vld) begin
          checks++;
          if (credit_q.size() == 0) begin
            errors++;
            $display("FAIL credit_unexpected: got size %0d, want no pulse", credit_size);
          end else begin
            c = credit_q.pop_front();
            if (credit_size !== 3'(c) || !lp) begin
              errors++;
              $display("FAIL credit: got size %0d after_last %0b, want size %0d after_last 1",
                       credit_size, lp, c);
            end
          end
        end else begin
          check("credit_size_idle", PW'(credit_size), PW'(0));
        end
        if (intr != 2'b00) begin
          checks++;
          if (intr_q.size() == 0) begin
            errors++;
            $display("FAIL intr_unexpected: got %b, want 00", intr);
          end else begin
            ei = intr_q.pop_front();
            if (intr !== ei || !lp) begin
              errors++;
              $display("FAIL done_intr: got %b after_last %0b, want %b after_last 1", intr, lp, ei);
            end
          end
        end
        nlp = 1'b0;
        if (cacc2sdp_valid && cacc2sdp_ready) begin
          checks++;
          if (beat_q.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected: got pd %0h, want none", cacc2sdp_pd);
          end else begin
            e = beat_q.pop_front();
            nlp = e.last;
            if (cacc2sdp_pd !== e.pd) begin
              errors++;
              $display("FAIL beat_pd: got %0h, want %0h", cacc2sdp_pd, e.pd);
            end
          end
        end
        if (cacc2sdp_valid && !cacc2sdp_ready) begin
          if (sp) check("stall_hold", cacc2sdp_pd, ppd);
          sp = 1'b1; ppd = cacc2sdp_pd;
        end else begin
          sp = 1'b0;
        end
        lp = nlp;
      end
    end
  end

  initial begin
    int first_v, low_cnt, guard;
    checks = 0; errors = 0; cnt_m = 0; sel_m = 1'b0;
    rst = 1'b1; dbuf_wr_en = 1'b0; dbuf_rd_en = 1'b0; dbuf_wr_addr = '0; dbuf_rd_addr = '0;
    dbuf_wr_data = '0; dbuf_rd_beats = '0; dbuf_rd_layer_end = 1'b0; cacc2sdp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_valid", PW'(cacc2sdp_valid), PW'(0));
    check("reset_rd_ready", PW'(dbuf_rd_ready), PW'(1));
    check("reset_pd", cacc2sdp_pd, PW'(0));
    check("reset_intr", PW'(intr), PW'(0));
    check("reset_credit_vld", PW'(credit_vld), PW'(0));
    @(posedge clk); #1;
    for (int a = 0; a < 8; a++) write_entry(a, pattern(a, 1));

    // Full entry: latency, LSB-first order, rd_ready low for exactly RATIO cycles.
    issue(3, 4, 1'b0, 1'b1, 1'b0, '0);
    first_v = 0; low_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (cacc2sdp_valid && first_v == 0) first_v = k;
      if (!dbuf_rd_ready) low_cnt++;
    end
    check("first_valid_latency", PW'(first_v), PW'(LAT));
    check("rd_ready_low_cycles", PW'(low_cnt), PW'(4));
    @(posedge clk); #1;

    // Partial entry closing a layer, then a second layer (beats=0 means full).
    issue(1, 2, 1'b1, 1'b1, 1'b0, '0);
    issue(2, 0, 1'b1, 1'b1, 1'b0, '0);

    // Backpressure 1,0,0,1 mid-entry.
    issue(4, 4, 1'b0, 1'b1, 1'b0, '0);
    cacc2sdp_ready = 1'b1;
    @(posedge clk); #1;
    cacc2sdp_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cacc2sdp_ready = 1'b1;

    // Flush the open batch, then 7 entries with a layer end on the last: 3,3,1.
    issue(0, 1, 1'b1, 1'b1, 1'b0, '0);
    for (int n = 0; n < 7; n++) issue(n, 1 + (n % RATIO), n == 6, 1'b1, 1'b0, '0);

    // Same-address write during read returns old data; the next read sees the new data.
    issue(5, 4, 1'b0, 1'b1, 1'b1, pattern(5, 2));
    issue(5, 3, 1'b1, 1'b1, 1'b0, '0);

    // Reset during the second beat drops the entry, its credit and its interrupt.
    issue(6, 4, 1'b1, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    beat_q.delete();
    cnt_m = 0; sel_m = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", PW'(cacc2sdp_valid), PW'(0));
    check("rst_mid_rd_ready", PW'(dbuf_rd_ready), PW'(1));
    check("rst_mid_credit", PW'(credit_vld), PW'(0));
    check("rst_mid_intr", PW'(intr), PW'(0));
    @(posedge clk); #1;
    issue(7, 3, 1'b1, 1'b1, 1'b0, '0);

    guard = 0;
    while ((beat_q.size() != 0 || credit_q.size() != 0 || intr_q.size() != 0) && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    repeat (4) @(posedge clk);
    check("beats_drained", PW'(beat_q.size()), PW'(0));
    check("credits_drained", PW'(credit_q.size()), PW'(0));
    check("intr_drained", PW'(intr_q.size()), PW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
